// File: rtl/rv32i_types.sv
// Shared core types; the store commit scheduler takes its FSM encoding from here.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    KICK
  } store_commit_state_t;

endpackage

// File: rtl/commit_tag_fifo.sv
// Generic FIFO with wrap-bit pointers; head_data is a combinational read of the oldest entry.
// Push while full and pop while empty are dropped internally; no same-cycle bypass in either direction.
module commit_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      head_q, head_d;
  logic [AW:0]      tail_q, tail_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra MSB distinguishes full from empty when the low index bits match.
  assign full      = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign empty     = (head_q == tail_q);
  assign head_data = mem_q[head_q[AW-1:0]];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    tail_d  = tail_q + {{AW{1'b0}}, do_push};
    head_d  = head_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/store_commit_sched.sv
// Drains retired stores to the dcache in commit order, one write at a time, then frees the tag.
// Commit to ISSUE takes 2 cycles from an empty idle queue; the tag kick follows dmem_resp by 1 cycle.
module store_commit_sched
  import rv32i_types::*;
#(
  parameter int TAG_DEPTH = 16,
  parameter int CQ_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         commit_valid,
  input  logic [$clog2(TAG_DEPTH)-1:0] commit_tag,
  output logic                         commit_ready,
  output logic [$clog2(TAG_DEPTH)-1:0] stq_rd_tag,
  input  logic [31:0]                  stq_rd_addr,
  input  logic [31:0]                  stq_rd_wdata,
  input  logic [3:0]                   stq_rd_wmask,
  output logic [31:0]                  dmem_addr,
  output logic [31:0]                  dmem_wdata,
  output logic [3:0]                   dmem_wmask,
  input  logic                         dmem_resp,
  output logic [$clog2(TAG_DEPTH)-1:0] wb_store_tag,
  output logic                         wb_store_tag_kick,
  output logic                         committed_pending
);

  localparam int TAG_W = $clog2(TAG_DEPTH);

  store_commit_state_t state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                kick_q, kick_d;
  logic [TAG_W-1:0]    head_tag;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  commit_tag_fifo #(
    .DEPTH (CQ_DEPTH),
    .WIDTH (TAG_W)
  ) u_commit_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (commit_valid && !fifo_full),
    .push_data (commit_tag),
    .pop       (fifo_pop),
    .head_data (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign commit_ready      = !fifo_full;
  assign stq_rd_tag        = head_tag;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign dmem_wmask        = (state_q == ISSUE) ? wmask_q : 4'h0;
  assign wb_store_tag      = tag_q;
  assign wb_store_tag_kick = kick_q;
  assign committed_pending = !fifo_empty || (state_q != IDLE);

  // The head entry stays in the FIFO until the dcache acknowledges it, so it
  // still counts toward full while the write is in flight.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    tag_d    = tag_q;
    kick_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          addr_d  = stq_rd_addr;
          wdata_d = stq_rd_wdata;
          wmask_d = stq_rd_wmask;
          tag_d   = head_tag;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (dmem_resp) begin
          fifo_pop = 1'b1;
          wmask_d  = 4'h0;
          kick_d   = 1'b1;
          state_d  = KICK;
        end
      end
      KICK: begin
        state_d = IDLE;
      end
      default: begin
        wmask_d = 4'h0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      tag_q   <= '0;
      kick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      tag_q   <= tag_d;
      kick_q  <= kick_d;
    end
  end

endmodule
